regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among three writeback requesters: ALU (0), LSU (1) and debug (2).
- Arbitrates round-robin and drives registered regwrite/write_reg/write_data into the register file.
- Keeps a per-register pending-write scoreboard so issue logic can stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width.
- NREG, 32, number of architectural registers (2**ADDR_W).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  3  per-requester write request valid; bit0 ALU, bit1 LSU, bit2 debug.
- req_ready  output  3  per-requester grant/accept, combinational.
- req_rd  input  3*ADDR_W  destination index per requester; slice i = bits [i*ADDR_W +: ADDR_W].
- req_data  input  3*DATA_W  write data per requester; same slicing.
- issue_valid  input  1  an instruction with a destination is issued this cycle.
- issue_rd  input  ADDR_W  destination of the issued instruction.
- rs1  input  ADDR_W  source index 1 for the hazard query.
- rs2  input  ADDR_W  source index 2 for the hazard query.
- hazard  output  1  combinational: rs1 or rs2 is nonzero and busy.
- busy  output  NREG  scoreboard vector; bit n = write pending to xn.
- regwrite  output  1  register-file write enable, registered.
- write_reg  output  ADDR_W  register-file write index, registered.
- write_data  output  DATA_W  register-file write data, registered.

Behaviour:
- Reset: reset is sampled on the rising clock edge; low = reset. Reset has priority over all other activity.
  - regwrite=0, write_reg=0, write_data=0, busy=0, rr_ptr=0 (last-granted index).
  - During reset, req_ready=0 and hazard is forced to 0.
- Arbitration, combinational each cycle:
  - Candidate order starts at (rr_ptr+1) mod 3 and wraps.
  - The first requester with req_valid set is granted; exactly one req_ready bit is high, or none if no valid.
- Transfer: occurs when req_valid[i] && req_ready[i]. A requester holds rd/data stable until it sees ready.
- Pointer update: on transfer, rr_ptr <= i. With no transfer, rr_ptr holds.
- Output register: one cycle latency from transfer to regwrite.
  - Edge after a transfer: regwrite<=1, write_reg<=req_rd[i], write_data<=req_data[i].
  - No transfer: regwrite<=0; write_reg and write_data hold their last values.
- x0 writes: the transfer is accepted (ready high, pointer advances) but regwrite<=0. Nothing is written to register 0.
- Scoreboard, per bit n, evaluated at the clock edge:
  - set_n = issue_valid && issue_rd==n && n!=0.
  - clr_n = transfer && granted rd==n.
  - If set_n, busy[n]<=1. Set wins over a simultaneous clear, because the newer instruction owns the register.
  - Else if clr_n, busy[n]<=0. Else hold.
  - busy[0] is always 0.
  - Clearing at transfer time is safe: the write lands the next edge, and forwarding is the pipeline's job.
- Hazard: hazard = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]). It reflects the registered busy only; same-cycle issue is not included.
- Debug writes: debug requests compete in the same rotation. They do not touch the scoreboard unless the pipeline issued that rd.
- Starvation bound: a continuously valid requester is granted within 3 cycles.
- Reset mid-operation:
  - A transfer in the same cycle as reset low is discarded: regwrite stays 0 and busy clears.
  - Requesters must re-present after reset.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all req_valid=1 -> req_ready=000, regwrite=0, busy=0, hazard=0. Release -> first grant goes to requester 1 (rr_ptr=0).
- Single write: ALU valid, rd=5, data=32'hDEADBEEF -> req_ready=001 the same cycle. Next cycle regwrite=1, write_reg=5, write_data=32'hDEADBEEF. Following cycle regwrite=0.
- Round-robin: all three valid continuously for 6 cycles from rr_ptr=0 -> grant sequence 1,2,0,1,2,0. Each regwrite carries the matching rd/data one cycle later.
- x0 suppression: LSU rd=0, data=32'h12345678 -> req_ready[1]=1 and rr_ptr=1, but regwrite stays 0. Issue of rd=0 leaves busy[0]=0.
- Scoreboard: issue rd=7; next cycle rs1=7 -> hazard=1. ALU writes rd=7 -> busy[7]=0 after that edge and hazard=0. Issue rd=9 and a transfer to rd=9 in the same cycle -> busy[9] stays 1.
- Mid-operation reset: ALU transfer to rd=3 in the same cycle reset=0, with busy[3]=1 -> next cycle regwrite=0, busy=0, rr_ptr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among ALU, LSU and debug,
// with a per-register pending-write scoreboard for RAW hazard detection.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NREG   = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [2:0]          req_valid,
   output logic [2:0]          req_ready,
   input  logic [3*ADDR_W-1:0] req_rd,
   input  logic [3*DATA_W-1:0] req_data,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_rd,
   input  logic [ADDR_W-1:0]   rs1,
   input  logic [ADDR_W-1:0]   rs2,
   output logic                hazard,
   output logic [NREG-1:0]     busy,
   output logic                regwrite,
   output logic [ADDR_W-1:0]   write_reg,
   output logic [DATA_W-1:0]   write_data
);

   logic [1:0]        rr_ptr;
   logic [1:0]        grant_idx;
   logic [1:0]        cand;
   logic              xfer;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic [NREG-1:0]   busy_next;

   function automatic logic [1:0] wrap_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Search starts just after the last winner; nothing is granted while in reset.
   always_comb begin
      xfer      = 1'b0;
      grant_idx = 2'd0;
      cand      = wrap_inc(rr_ptr);
      for (int k = 0; k < 3; k++) begin
         if (!xfer && req_valid[cand]) begin
            xfer      = 1'b1;
            grant_idx = cand;
         end
         cand = wrap_inc(cand);
      end
      if (!reset) xfer = 1'b0;
   end

   always_comb begin
      req_ready = 3'b000;
      if (xfer) req_ready[grant_idx] = 1'b1;
   end

   assign sel_rd   = req_rd[32'(grant_idx)*ADDR_W +: ADDR_W];
   assign sel_data = req_data[32'(grant_idx)*DATA_W +: DATA_W];

   // Issue is applied after the clear so the newer instruction keeps ownership.
   always_comb begin
      busy_next = busy;
      if (xfer) busy_next[sel_rd] = 1'b0;
      if (issue_valid) busy_next[issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   assign hazard = reset && (((rs1 != '0) && busy[rs1]) || ((rs2 != '0) && busy[rs2]));

   always_ff @(posedge clock) begin
      if (!reset) begin
         rr_ptr     <= 2'd0;
         regwrite   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         busy       <= '0;
      end else begin
         busy     <= busy_next;
         regwrite <= 1'b0;
         if (xfer) begin
            rr_ptr <= grant_idx;
            // x0 transfers are accepted but never reach the register file.
            if (sel_rd != '0) begin
               regwrite   <= 1'b1;
               write_reg  <= sel_rd;
               write_data <= sel_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NREG   = 32;

   logic                clock;
   logic                reset;
   logic [2:0]          req_valid;
   logic [2:0]          req_ready;
   logic [3*ADDR_W-1:0] req_rd;
   logic [3*DATA_W-1:0] req_data;
   logic                issue_valid;
   logic [ADDR_W-1:0]   issue_rd;
   logic [ADDR_W-1:0]   rs1;
   logic [ADDR_W-1:0]   rs2;
   logic                hazard;
   logic [NREG-1:0]     busy;
   logic                regwrite;
   logic [ADDR_W-1:0]   write_reg;
   logic [DATA_W-1:0]   write_data;

   regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_rd(req_rd), .req_data(req_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1(rs1), .rs2(rs2), .hazard(hazard), .busy(busy), .regwrite(regwrite),
      .write_reg(write_reg), .write_data(write_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus state: pending requests per requester, plus issue/query inputs
   bit              rst_v;
   bit              pv[3];
   bit [ADDR_W-1:0] prd[3];
   bit [DATA_W-1:0] pdata[3];
   bit              iv;
   bit [ADDR_W-1:0] ird, r1, r2;

   // reference model state
   int              m_last;
   bit [NREG-1:0]   m_busy;
   bit              m_rw;
   bit [ADDR_W-1:0] m_wreg;
   bit [DATA_W-1:0] m_wdata;
   int              m_grant;
   logic [2:0]      obs_ready;
   logic            obs_hazard;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic run_cycle();
      logic [2:0] exp_ready;
      bit         exp_haz;
      reset       = rst_v;
      issue_valid = iv;
      issue_rd    = ird;
      rs1         = r1;
      rs2         = r2;
      for (int i = 0; i < 3; i++) begin
         req_valid[i]                = pv[i];
         req_rd[i*ADDR_W +: ADDR_W]  = prd[i];
         req_data[i*DATA_W +: DATA_W] = pdata[i];
      end
      #1;
      m_grant = -1;
      if (rst_v)
         for (int k = 1; k <= 3; k++)
            if (m_grant < 0 && pv[(m_last + k) % 3]) m_grant = (m_last + k) % 3;
      exp_ready = (m_grant >= 0) ? 3'(1 << m_grant) : 3'b000;
      exp_haz = rst_v && ((r1 != 0 && m_busy[r1]) || (r2 != 0 && m_busy[r2]));
      obs_ready  = req_ready;
      obs_hazard = hazard;
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      check_eq("hazard", 64'(hazard), 64'(exp_haz));
      @(posedge clock);
      if (!rst_v) begin
         m_last = 0; m_busy = '0; m_rw = 0; m_wreg = '0; m_wdata = '0;
      end else begin
         m_rw = 0;
         if (m_grant >= 0) begin
            m_last = m_grant;
            m_busy[prd[m_grant]] = 1'b0;
            if (prd[m_grant] != 0) begin
               m_rw = 1; m_wreg = prd[m_grant]; m_wdata = pdata[m_grant];
            end
            pv[m_grant] = 0;
         end
         if (iv && ird != 0) m_busy[ird] = 1'b1;
      end
      @(negedge clock);
      check_eq("regwrite", 64'(regwrite), 64'(m_rw));
      check_eq("write_reg", 64'(write_reg), 64'(m_wreg));
      check_eq("write_data", 64'(write_data), 64'(m_wdata));
      check_eq("busy", 64'(busy), 64'(m_busy));
   endtask

   task automatic quiet();
      rst_v = 1; iv = 0; ird = '0; r1 = '0; r2 = '0;
      for (int i = 0; i < 3; i++) pv[i] = 0;
   endtask

   initial begin
      int exp_seq[6] = '{1, 2, 0, 1, 2, 0};
      m_last = 0; m_busy = '0; m_rw = 0; m_wreg = '0; m_wdata = '0;
      quiet();
      rst_v = 0;
      for (int i = 0; i < 3; i++) begin
         pv[i] = 1; prd[i] = 5'(i + 1); pdata[i] = 32'(i * 16 + 1);
      end
      reset = 0; req_valid = '0; req_rd = '0; req_data = '0;
      issue_valid = 0; issue_rd = '0; rs1 = '0; rs2 = '0;
      @(negedge clock);

      // reset held with everyone requesting
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 3; i++) pv[i] = 1;
         run_cycle();
         check_eq("rst_ready", 64'(obs_ready), 64'(3'b000));
      end

      // round-robin after release, all continuously valid
      rst_v = 1;
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < 3; i++) begin
            pv[i] = 1; prd[i] = 5'(10 + c * 3 + i); pdata[i] = 32'($urandom);
         end
         run_cycle();
         check_eq("rr_seq", 64'(m_grant), 64'(exp_seq[c]));
         check_eq("rr_wreg", 64'(write_reg), 64'(10 + c * 3 + exp_seq[c]));
      end

      // single ALU write
      quiet();
      pv[0] = 1; prd[0] = 5'd5; pdata[0] = 32'hDEADBEEF;
      run_cycle();
      check_eq("single_ready", 64'(obs_ready), 64'(3'b001));
      check_eq("single_data", 64'(write_data), 64'(32'hDEADBEEF));
      quiet();
      run_cycle();
      check_eq("single_idle", 64'(regwrite), 64'(0));

      // x0 suppression, plus issue of x0
      quiet();
      pv[1] = 1; prd[1] = 5'd0; pdata[1] = 32'h12345678; iv = 1; ird = 5'd0;
      run_cycle();
      check_eq("x0_ready", 64'(obs_ready), 64'(3'b010));
      check_eq("x0_regwrite", 64'(regwrite), 64'(0));
      check_eq("x0_busy0", 64'(busy[0]), 64'(0));
      quiet();
      for (int i = 0; i < 3; i++) pv[i] = 1;
      run_cycle();
      check_eq("x0_ptr", 64'(obs_ready), 64'(3'b100));

      // scoreboard set / hazard / clear / set-wins
      quiet(); iv = 1; ird = 5'd7;
      run_cycle();
      quiet(); r1 = 5'd7; pv[0] = 1; prd[0] = 5'd7; pdata[0] = 32'hA5A5A5A5;
      run_cycle();
      check_eq("sb_hazard", 64'(obs_hazard), 64'(1));
      check_eq("sb_clear", 64'(busy[7]), 64'(0));
      quiet(); r1 = 5'd7;
      run_cycle();
      check_eq("sb_nohazard", 64'(obs_hazard), 64'(0));
      quiet(); iv = 1; ird = 5'd9; pv[0] = 1; prd[0] = 5'd9; pdata[0] = 32'h99;
      run_cycle();
      check_eq("sb_setwins", 64'(busy[9]), 64'(1));

      // mid-operation reset with a transfer in flight
      quiet(); iv = 1; ird = 5'd3;
      run_cycle();
      quiet(); rst_v = 0; pv[0] = 1; prd[0] = 5'd3; pdata[0] = 32'h33;
      run_cycle();
      check_eq("mid_rst_rw", 64'(regwrite), 64'(0));
      check_eq("mid_rst_busy", 64'(busy), 64'(0));
      quiet();
      for (int i = 0; i < 3; i++) pv[i] = 1;
      run_cycle();
      check_eq("mid_rst_ptr", 64'(obs_ready), 64'(3'b010));

      // randomized traffic with occasional reset
      quiet();
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 3; i++)
            if (!pv[i] && ($urandom_range(0, 3) != 0)) begin
               pv[i] = 1;
               prd[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               pdata[i] = 32'($urandom);
            end
         rst_v = ($urandom_range(0, 49) != 0);
         iv  = 1'($urandom_range(0, 1));
         ird = 5'($urandom_range(0, 31));
         r1  = 5'($urandom_range(0, 31));
         r2  = 5'($urandom_range(0, 31));
         run_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
